// File: rtl/rc4_key_search_ctrl_if.sv
// Engine handshake and S-memory owner select between the key-search sequencer
// and the init/KSA/decrypt engines.
interface rc4_key_search_ctrl_if;
    logic       init_start;
    logic       init_done;
    logic       ksa_start;
    logic       ksa_done;
    logic       dec_start;
    logic       dec_done;
    logic       dec_key_found;
    logic [1:0] s_mem_sel;

    modport master (
        output init_start, ksa_start, dec_start, s_mem_sel,
        input  init_done, ksa_done, dec_done, dec_key_found
    );

    modport slave (
        input  init_start, ksa_start, dec_start, s_mem_sel,
        output init_done, ksa_done, dec_done, dec_key_found
    );
endinterface

// File: rtl/rc4_key_search_ctrl.sv
// RC4 brute-force key search sequencer: per candidate key runs S-init, KSA, then
// decrypt/validate, owning the S-memory select so only one engine writes at a time.
module rc4_key_search_ctrl #(
    parameter int unsigned          KEY_WIDTH = 24,
    parameter logic [KEY_WIDTH-1:0] KEY_START = '0,
    parameter logic [KEY_WIDTH-1:0] KEY_END   = 24'h3FFFFF
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic                    start_i,
    rc4_key_search_ctrl_if.master   eng,
    output logic [KEY_WIDTH-1:0]    secret_key_o,
    output logic                    busy_o,
    output logic                    key_found_o,
    output logic                    key_exhausted_o,
    output logic                    done_o
);

    typedef enum logic [3:0] {
        StIdle,
        StInitGo,
        StInitWait,
        StKsaGo,
        StKsaWait,
        StDecGo,
        StDecWait,
        StNextKey,
        StFinish
    } state_e;

    localparam logic [1:0] SelInit = 2'd0;
    localparam logic [1:0] SelKsa  = 2'd1;
    localparam logic [1:0] SelDec  = 2'd2;
    localparam logic [1:0] SelNone = 2'd3;

    state_e               state_q;
    logic [KEY_WIDTH-1:0] key_q;
    logic [1:0]           sel_q;
    logic                 init_start_q;
    logic                 ksa_start_q;
    logic                 dec_start_q;
    logic                 busy_q;
    logic                 found_q;
    logic                 exhausted_q;
    logic                 done_q;

    // Outputs are registered and loaded on the transition into each state, so
    // start pulses and the select line line up exactly with the state they belong to.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= StIdle;
            key_q        <= KEY_START;
            sel_q        <= SelNone;
            init_start_q <= 1'b0;
            ksa_start_q  <= 1'b0;
            dec_start_q  <= 1'b0;
            busy_q       <= 1'b0;
            found_q      <= 1'b0;
            exhausted_q  <= 1'b0;
            done_q       <= 1'b0;
        end else begin
            init_start_q <= 1'b0;
            ksa_start_q  <= 1'b0;
            dec_start_q  <= 1'b0;
            done_q       <= 1'b0;
            case (state_q)
                StIdle: begin
                    if (start_i) begin
                        state_q      <= StInitGo;
                        key_q        <= KEY_START;
                        found_q      <= 1'b0;
                        exhausted_q  <= 1'b0;
                        busy_q       <= 1'b1;
                        init_start_q <= 1'b1;
                        sel_q        <= SelInit;
                    end
                end
                StInitGo: state_q <= StInitWait;
                StInitWait: begin
                    if (eng.init_done) begin
                        state_q     <= StKsaGo;
                        ksa_start_q <= 1'b1;
                        sel_q       <= SelKsa;
                    end
                end
                StKsaGo: state_q <= StKsaWait;
                StKsaWait: begin
                    if (eng.ksa_done) begin
                        state_q     <= StDecGo;
                        dec_start_q <= 1'b1;
                        sel_q       <= SelDec;
                    end
                end
                StDecGo: state_q <= StDecWait;
                StDecWait: begin
                    if (eng.dec_done) begin
                        sel_q <= SelNone;
                        // A hit on the last key counts as success, not exhaustion.
                        if (eng.dec_key_found) begin
                            state_q <= StFinish;
                            found_q <= 1'b1;
                            done_q  <= 1'b1;
                        end else if (key_q == KEY_END) begin
                            state_q     <= StFinish;
                            exhausted_q <= 1'b1;
                            done_q      <= 1'b1;
                        end else begin
                            state_q <= StNextKey;
                        end
                    end
                end
                StNextKey: begin
                    state_q      <= StInitGo;
                    key_q        <= key_q + KEY_WIDTH'(1);
                    init_start_q <= 1'b1;
                    sel_q        <= SelInit;
                end
                StFinish: begin
                    state_q <= StIdle;
                    busy_q  <= 1'b0;
                end
                default: begin
                    state_q <= StIdle;
                    busy_q  <= 1'b0;
                    sel_q   <= SelNone;
                end
            endcase
        end
    end

    assign eng.init_start  = init_start_q;
    assign eng.ksa_start   = ksa_start_q;
    assign eng.dec_start   = dec_start_q;
    assign eng.s_mem_sel   = sel_q;
    assign secret_key_o    = key_q;
    assign busy_o          = busy_q;
    assign key_found_o     = found_q;
    assign key_exhausted_o = exhausted_q;
    assign done_o          = done_q;

endmodule

// File: tb/tb_rc4_key_search_ctrl.sv
// Bench for rc4_key_search_ctrl: behavioural 3-cycle engines, a table of whole
// searches, and hand-driven handshake corner cases.
module tb_rc4_key_search_ctrl;

    localparam int unsigned KW = 24;

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic          start = 1'b0;
    logic [KW-1:0] secret_key;
    logic          busy, key_found, key_exhausted, done;

    rc4_key_search_ctrl_if bus ();

    rc4_key_search_ctrl #(
        .KEY_WIDTH (KW),
        .KEY_START (24'd0),
        .KEY_END   (24'd5)
    ) dut (
        .clk             (clk),
        .reset_n         (reset_n),
        .start_i         (start),
        .eng             (bus.master),
        .secret_key_o    (secret_key),
        .busy_o          (busy),
        .key_found_o     (key_found),
        .key_exhausted_o (key_exhausted),
        .done_o          (done)
    );

    always #5 clk = ~clk;

    // Manual (hand-driven) and automatic (model) engine responses are ORed.
    logic m_init_done = 1'b0, m_ksa_done = 1'b0, m_dec_done = 1'b0, m_found = 1'b0;
    logic a_init_done = 1'b0, a_ksa_done = 1'b0, a_dec_done = 1'b0, a_found = 1'b0;
    assign bus.init_done     = m_init_done | a_init_done;
    assign bus.ksa_done      = m_ksa_done | a_ksa_done;
    assign bus.dec_done      = m_dec_done | a_dec_done;
    assign bus.dec_key_found = m_found | a_found;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic auto_en = 1'b0;
    int   target = -1;
    int   base_dec = 0;
    int   ci = 0, ck = 0, cd = 0;
    int   n_init = 0, n_ksa = 0, n_dec = 0, n_done = 0, n_bubble = 0;
    int   t_done = 0;

    // Engine model plus pulse monitor; target is a round index from search start.
    always @(negedge clk) begin
        a_init_done = 1'b0;
        a_ksa_done  = 1'b0;
        a_dec_done  = 1'b0;
        a_found     = 1'b0;
        if (!reset_n) begin
            ci = 0;
            ck = 0;
            cd = 0;
        end else begin
            if (ci != 0) begin
                ci = ci - 1;
                if (ci == 0 && auto_en) a_init_done = 1'b1;
            end
            if (ck != 0) begin
                ck = ck - 1;
                if (ck == 0 && auto_en) a_ksa_done = 1'b1;
            end
            if (cd != 0) begin
                cd = cd - 1;
                if (cd == 0 && auto_en) begin
                    a_dec_done = 1'b1;
                    a_found    = ((n_dec - base_dec - 1) == target);
                end
            end
            if (bus.init_start) begin ci = 3; n_init = n_init + 1; end
            if (bus.ksa_start)  begin ck = 3; n_ksa  = n_ksa + 1;  end
            if (bus.dec_start)  begin cd = 3; n_dec  = n_dec + 1;  end
            if (done) begin n_done = n_done + 1; t_done = cyc; end
            if (busy && bus.s_mem_sel == 2'd3) n_bubble = n_bubble + 1;
        end
    end

    int n_checks = 0;
    int n_fail = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks = n_checks + 1;
        if (act !== exp) begin
            n_fail = n_fail + 1;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    typedef struct {
        int          tgt;
        logic [31:0] key;
        logic        found;
        logic        exh;
        int          rounds;
    } vec_t;

    vec_t vecs[5];

    task automatic run_vec(input vec_t v, input int idx);
        int i0, k0, d0, dn0, b0, t0, k;
        string tag;
        tag      = $sformatf("v%0d", idx);
        target   = v.tgt;
        base_dec = n_dec;
        i0 = n_init; k0 = n_ksa; d0 = n_dec; dn0 = n_done; b0 = n_bubble;
        start = 1'b1;
        step();
        start = 1'b0;
        chk({tag, "_init_start_latency"}, 32'(bus.init_start), 32'd1);
        t0 = cyc;
        k = 0;
        while (n_done == dn0 && k < 3000) begin
            step();
            k = k + 1;
        end
        step();
        step();
        chk({tag, "_done_pulses"}, 32'(n_done - dn0), 32'd1);
        chk({tag, "_busy"}, 32'(busy), 32'd0);
        chk({tag, "_key"}, 32'(secret_key), v.key);
        chk({tag, "_found"}, 32'(key_found), 32'(v.found));
        chk({tag, "_exhausted"}, 32'(key_exhausted), 32'(v.exh));
        chk({tag, "_dec_rounds"}, 32'(n_dec - d0), 32'(v.rounds));
        chk({tag, "_init_rounds"}, 32'(n_init - i0), 32'(v.rounds));
        chk({tag, "_ksa_rounds"}, 32'(n_ksa - k0), 32'(v.rounds));
        chk({tag, "_sel3_busy_cycles"}, 32'(n_bubble - b0), 32'(v.rounds));
        chk({tag, "_cycles_to_done"}, 32'(t_done - t0), 32'(13 * (v.rounds - 1) + 12));
        chk({tag, "_sel_idle"}, 32'(bus.s_mem_sel), 32'd3);
    endtask

    int i_snap;

    initial begin
        vecs[0] = '{tgt: 0,  key: 32'd0, found: 1'b1, exh: 1'b0, rounds: 1};
        vecs[1] = '{tgt: 3,  key: 32'd3, found: 1'b1, exh: 1'b0, rounds: 4};
        vecs[2] = '{tgt: -1, key: 32'd5, found: 1'b0, exh: 1'b1, rounds: 6};
        vecs[3] = '{tgt: 5,  key: 32'd5, found: 1'b1, exh: 1'b0, rounds: 6};
        vecs[4] = '{tgt: 1,  key: 32'd1, found: 1'b1, exh: 1'b0, rounds: 2};

        repeat (3) step();
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_sel", 32'(bus.s_mem_sel), 32'd3);
        chk("rst_key", 32'(secret_key), 32'd0);
        chk("rst_flags", 32'({key_found, key_exhausted, done}), 32'd0);
        chk("rst_starts", 32'({bus.init_start, bus.ksa_start, bus.dec_start}), 32'd0);
        reset_n = 1'b1;
        step();

        // Hand-driven handshakes: same-cycle and out-of-state dones, start while busy.
        start = 1'b1;
        step();
        chk("h_init_go", 32'({bus.init_start, bus.s_mem_sel, busy}), 32'b1001);
        start = 1'b0;
        m_init_done = 1'b1;
        step();
        chk("h_same_cycle_init_done", 32'({bus.init_start, bus.ksa_start, bus.s_mem_sel}),
            32'b0000);
        m_init_done = 1'b0;
        m_ksa_done  = 1'b1;
        step();
        chk("h_spurious_ksa_done", 32'({bus.ksa_start, bus.s_mem_sel}), 32'b000);
        m_ksa_done  = 1'b0;
        m_init_done = 1'b1;
        step();
        chk("h_ksa_go", 32'({bus.ksa_start, bus.s_mem_sel}), 32'b101);
        m_init_done = 1'b0;
        m_ksa_done  = 1'b1;
        step();
        chk("h_same_cycle_ksa_done", 32'({bus.ksa_start, bus.dec_start, bus.s_mem_sel}),
            32'b0001);
        step();
        chk("h_dec_go", 32'({bus.dec_start, bus.s_mem_sel}), 32'b110);
        m_ksa_done = 1'b0;
        step();
        start = 1'b1;
        step();
        chk("h_start_while_busy", 32'({bus.init_start, bus.s_mem_sel, busy}), 32'b0101);
        start = 1'b0;
        m_dec_done = 1'b1;
        step();
        chk("h_next_key_bubble", 32'({bus.init_start, bus.s_mem_sel, busy}), 32'b0111);
        chk("h_next_key_key", 32'(secret_key), 32'd0);
        m_dec_done = 1'b0;
        step();
        chk("h_second_init_go", 32'({bus.init_start, bus.s_mem_sel}), 32'b100);
        chk("h_second_key", 32'(secret_key), 32'd1);
        step();
        m_init_done = 1'b1;
        step();
        m_init_done = 1'b0;
        step();
        chk("h_ksa_wait_key1", 32'({bus.s_mem_sel, secret_key[3:0]}), 32'b010001);

        // Asynchronous reset mid-search must take effect before the next edge.
        reset_n = 1'b0;
        #1;
        chk("r_busy", 32'(busy), 32'd0);
        chk("r_sel", 32'(bus.s_mem_sel), 32'd3);
        chk("r_key", 32'(secret_key), 32'd0);
        chk("r_flags", 32'({key_found, key_exhausted}), 32'd0);
        step();
        reset_n = 1'b1;
        i_snap = n_init;
        repeat (6) step();
        chk("r_no_restart", 32'(n_init - i_snap), 32'd0);
        chk("r_idle_busy", 32'(busy), 32'd0);

        auto_en = 1'b1;
        for (int v = 0; v < 5; v++) run_vec(vecs[v], v);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
